// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits
// in the EX stage beside the ALU and serves mult, multu, div, divu, mthi and
// mtlo. The unit models fixed-latency iterative hardware: an accepted
// multiply or divide holds busy high for a fixed number of cycles. The
// pipeline controller stalls dependent instructions on stall_req while an
// operation is in flight.
//
// Parameters:
//   WIDTH       operand width; HI and LO are each WIDTH bits
//   MUL_CYCLES  busy cycles for the multiply class (>= 1)
//   DIV_CYCLES  busy cycles for the divide class (>= 1)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high
//   start      issue strobe, sampled on the rising edge
//   op[3:0]    0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//              6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU, others NOP
//   a, b       rs / rt operands
//   busy       an operation is in flight (registered)
//   stall_req  busy | (start & op is multi-cycle), combinational
//   hi_out     current HI register
//   lo_out     current LO register
//
// Configuration macro: MDU_MADD_EN
//   When defined, ops 6-9 accumulate the product into {HI,LO} with
//   MUL_CYCLES latency. When undefined, ops 6-9 decode as NOP.
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MTHI  = 4'd4,
        OP_MTLO  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e            state;
    logic [CW-1:0]     cnt;
    logic [3:0]        pend_op;
    logic [WIDTH-1:0]  pend_a;
    logic [WIDTH-1:0]  pend_b;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;

    logic              is_mul;
    logic              is_div;
    logic              is_mac;
    logic              is_multi;

    // Issue decode: which ops occupy the unit for several cycles.
    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
        is_div = (op == OP_DIV)  || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        is_mac = (op == OP_MADD) || (op == OP_MADDU) ||
                 (op == OP_MSUB) || (op == OP_MSUBU);
`else
        is_mac = 1'b0;
`endif
        is_multi = is_mul | is_div | is_mac;
    end

    assign stall_req = busy | (start & is_multi);
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

    logic [2*WIDTH-1:0] ext_a_s;
    logic [2*WIDTH-1:0] ext_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   sq_mag;
    logic [WIDTH-1:0]   sr_mag;
    logic [WIDTH-1:0]   sq;
    logic [WIDTH-1:0]   sr;
    logic [WIDTH-1:0]   div_b;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;
    logic               div_zero;

    // Arithmetic on the captured operands.
    // Signed division works on magnitudes and restores the signs afterwards,
    // so the quotient truncates toward zero and the remainder follows the
    // dividend. For min_int / -1 the quotient magnitude is 2^(WIDTH-1),
    // whose bit pattern is min_int again, and the remainder is 0. That is
    // the required overflow result, with no special case.
    // A zero divisor is replaced by 1 only to keep the dividers defined; that
    // result is never committed.
    always_comb begin
        ext_a_s  = {{WIDTH{pend_a[WIDTH-1]}}, pend_a};
        ext_b_s  = {{WIDTH{pend_b[WIDTH-1]}}, pend_b};
        prod_s   = ext_a_s * ext_b_s;
        prod_u   = {{WIDTH{1'b0}}, pend_a} * {{WIDTH{1'b0}}, pend_b};

        div_zero = (pend_b == '0);
        div_b    = div_zero ? WIDTH'(1) : pend_b;

        sign_a   = pend_a[WIDTH-1];
        sign_b   = pend_b[WIDTH-1];
        mag_a    = sign_a ? (~pend_a + WIDTH'(1)) : pend_a;
        mag_b    = div_zero ? WIDTH'(1) :
                   (sign_b ? (~pend_b + WIDTH'(1)) : pend_b);
        sq_mag   = mag_a / mag_b;
        sr_mag   = mag_a % mag_b;
        sq       = (sign_a ^ sign_b) ? (~sq_mag + WIDTH'(1)) : sq_mag;
        sr       = sign_a ? (~sr_mag + WIDTH'(1)) : sr_mag;

        uq       = pend_a / div_b;
        ur       = pend_a % div_b;
    end

    logic [2*WIDTH-1:0] result;
    logic               commit_en;

    // Select the value written to {HI,LO} on the commit edge. The
    // accumulate forms read the live HI/LO, so they see the registers at
    // commit time.
    always_comb begin
        result    = {hi_q, lo_q};
        commit_en = 1'b1;
        case (pend_op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV: begin
                result    = {sr, sq};
                commit_en = ~div_zero;
            end
            OP_DIVU: begin
                result    = {ur, uq};
                commit_en = ~div_zero;
            end
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi_q, lo_q} + prod_s;
            OP_MADDU: result = {hi_q, lo_q} + prod_u;
            OP_MSUB:  result = {hi_q, lo_q} - prod_s;
            OP_MSUBU: result = {hi_q, lo_q} - prod_u;
`endif
            default:  commit_en = 1'b0;
        endcase
    end

    // Control FSM, operand capture and HI/LO update.
    // The counter loads N on acceptance and counts down. The edge that sees
    // it at 1 commits and drops busy, so busy is high for exactly N cycles.
    // Starts arriving while busy are dropped. The controller keeps the
    // instruction held via stall_req.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pend_op <= '0;
            pend_a  <= '0;
            pend_b  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_multi) begin
                            state   <= S_RUN;
                            busy    <= 1'b1;
                            cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                            pend_op <= op;
                            pend_a  <= a;
                            pend_b  <= b;
                        end else if (op == OP_MTHI) begin
                            hi_q <= a;
                        end else if (op == OP_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt == CW'(1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (commit_en) begin
                            hi_q <= result[2*WIDTH-1:WIDTH];
                            lo_q <= result[WIDTH-1:0];
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
